// File: rtl/voxel_ram_loader_if.sv
// Byte-stream input and single-bit RAM write port of the voxel RAM loader.
// The loader takes the slave side; the producer/RAM side takes the master side.
interface voxel_ram_loader_if #(
  parameter int ADDR_BITS = 15
) ();
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_ready;
  logic                 we;
  logic [ADDR_BITS-1:0] waddr;
  logic                 wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, we, waddr, wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, we, waddr, wdata
  );
endinterface

// File: rtl/voxel_ram_loader.sv
// Write-side front end for the voxel occupancy RAM: unpacks a byte stream into
// single-bit writes at ascending addresses, or zero-fills the whole RAM.
module voxel_ram_loader #(
  parameter int ADDR_BITS = 15,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_start,
  input  logic              load_start,
  input  logic              abort,
  voxel_ram_loader_if.slave bus,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    LOAD_WAIT,
    LOAD_SHIFT
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] addr;
  logic [2:0]           bitcnt;
  logic [7:0]           shreg;

  logic                 last_bit;
  logic                 at_end;
  logic                 ready;
  logic [2:0]           bit_sel;

  assign last_bit = (bitcnt == 3'd7);
  assign at_end   = (addr == LAST_ADDR);
  // A follow-on byte may only be taken on the last bit of a group that is not the final group.
  assign ready    = (state == LOAD_WAIT) ||
                    ((state == LOAD_SHIFT) && last_bit && !at_end);
  assign bit_sel  = LSB_FIRST ? bitcnt : ~bitcnt;

  assign bus.in_ready = ready;
  assign bus.we       = (state == CLEAR) || (state == LOAD_SHIFT);
  assign bus.waddr    = addr;
  assign bus.wdata    = (state == LOAD_SHIFT) ? shreg[bit_sel] : 1'b0;
  assign busy         = (state != IDLE);

  // Abort overrides everything outside IDLE; the write shown this cycle still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state != IDLE) && abort) begin
        state  <= IDLE;
        addr   <= '0;
        bitcnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (clear_start) begin
              state <= CLEAR;
              addr  <= '0;
            end else if (load_start) begin
              state <= LOAD_WAIT;
              addr  <= '0;
            end
          end
          CLEAR: begin
            addr <= addr + 1'b1;
            if (at_end) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          LOAD_WAIT: begin
            if (bus.in_valid) begin
              shreg  <= bus.in_data;
              bitcnt <= '0;
              state  <= LOAD_SHIFT;
            end
          end
          LOAD_SHIFT: begin
            addr   <= addr + 1'b1;
            bitcnt <= bitcnt + 3'd1;
            if (last_bit) begin
              if (at_end) begin
                state <= IDLE;
                done  <= 1'b1;
              end else if (bus.in_valid) begin
                shreg <= bus.in_data;
              end else begin
                state <= LOAD_WAIT;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voxel_ram_loader.sv
// Randomized bench for voxel_ram_loader: two instances (LSB-first and MSB-first)
// share all stimulus and are compared against a RAM-image model of the byte stream.
module tb_voxel_ram_loader;
  localparam int AB    = 6;
  localparam int DEPTH = 1 << AB;

  logic clk = 1'b0;
  logic rst_n;
  logic clear_start, load_start, abort;
  logic in_valid;
  logic [7:0] in_data;
  logic busy0, done0, busy1, done1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [AB-1:0] wr_addr[$];
  logic          wr_d0[$];
  logic          wr_d1[$];
  int            wr_cyc[$];
  logic [7:0]    hs_data[$];
  int            hs_cyc[$];
  int            done_cyc[$];
  int            done_err;
  int            lock_err;
  int            ready_cnt;

  voxel_ram_loader_if #(.ADDR_BITS(AB)) if0 ();
  voxel_ram_loader_if #(.ADDR_BITS(AB)) if1 ();

  assign if0.in_valid = in_valid;
  assign if0.in_data  = in_data;
  assign if1.in_valid = in_valid;
  assign if1.in_data  = in_data;

  voxel_ram_loader #(.ADDR_BITS(AB), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .load_start(load_start),
    .abort(abort), .bus(if0), .busy(busy0), .done(done0)
  );

  voxel_ram_loader #(.ADDR_BITS(AB), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .load_start(load_start),
    .abort(abort), .bus(if1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the RAM port and handshakes mid-cycle, when everything is stable.
  always @(negedge clk) begin
    if (if0.we) begin
      wr_addr.push_back(if0.waddr);
      wr_d0.push_back(if0.wdata);
      wr_d1.push_back(if1.wdata);
      wr_cyc.push_back(cyc);
    end
    if (in_valid && if0.in_ready) begin
      hs_data.push_back(in_data);
      hs_cyc.push_back(cyc);
    end
    if (done0) begin
      done_cyc.push_back(cyc);
      if (busy0 || if0.we) done_err++;
    end
    if (if0.in_ready) ready_cnt++;
    if ((if0.we !== if1.we) || (if0.waddr !== if1.waddr) || (if0.in_ready !== if1.in_ready) ||
        (done0 !== done1) || (busy0 !== busy1))
      lock_err++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic resetLogs();
    wr_addr.delete(); wr_d0.delete(); wr_d1.delete(); wr_cyc.delete();
    hs_data.delete(); hs_cyc.delete(); done_cyc.delete();
    done_err = 0; lock_err = 0; ready_cnt = 0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (busy0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle"}, busy0, 0);
    @(posedge clk); #1;
  endtask

  // Zero-fill; optionally collides load_start with clear_start, and always pokes load_start mid-clear.
  task automatic runClear(input string tag, input bit both);
    int bad_addr = 0;
    int bad_data = 0;
    resetLogs();
    clear_start = 1'b1; load_start = both;
    @(posedge clk); #1;
    clear_start = 1'b0; load_start = 1'b0;
    repeat (10) @(posedge clk);
    #1 load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    waitIdle(tag, 200);
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < wr_addr.size(); i++) begin
      if (int'(wr_addr[i]) != i) bad_addr++;
      if (wr_d0[i] !== 1'b0 || wr_d1[i] !== 1'b0) bad_data++;
    end
    checkOutput({tag, "_writes"}, wr_addr.size(), DEPTH);
    checkOutput({tag, "_addr_seq"}, bad_addr, 0);
    checkOutput({tag, "_data_zero"}, bad_data, 0);
    if (wr_cyc.size() > 0) checkOutput({tag, "_span"}, wr_cyc[$] - wr_cyc[0], DEPTH - 1);
    checkOutput({tag, "_done_count"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0 && wr_cyc.size() > 0)
      checkOutput({tag, "_done_lag"}, done_cyc[0] - wr_cyc[$], 1);
    checkOutput({tag, "_done_busy_we"}, done_err, 0);
    checkOutput({tag, "_in_ready_seen"}, ready_cnt, 0);
    checkOutput({tag, "_late_load_ignored"}, busy0, 0);
    checkOutput({tag, "_lockstep"}, lock_err, 0);
  endtask

  // Drives a load: byte 0xA5, byte 0x01, then random bytes; gaps counted in ready cycles.
  task automatic applyStimulus(input string tag, input int gap, input bit rand_gap, input int abort_at);
    logic [7:0] tx[$];
    int  wait_cnt = 0;
    int  budget = 4000;
    bit  hs = 1'b0;
    resetLogs();
    tx.push_back(8'hA5);
    tx.push_back(8'h01);
    for (int i = 0; i < 8; i++) tx.push_back(8'($urandom_range(0, 255)));
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    while (budget > 0) begin
      if (hs) begin
        tx.delete(0);
        wait_cnt = rand_gap ? int'($urandom_range(0, 4)) : gap;
      end
      if (wait_cnt > 0) begin
        in_valid = 1'b0;
        if (if0.in_ready) wait_cnt--;
      end else begin
        in_valid = (tx.size() > 0);
        if (tx.size() > 0) in_data = tx[0];
      end
      abort = (abort_at >= 0) && if0.we && (int'(if0.waddr) == abort_at);
      @(negedge clk);
      hs = in_valid && if0.in_ready;
      if (!busy0) break;
      @(posedge clk); #1;
      budget--;
    end
    in_valid = 1'b0;
    abort = 1'b0;
    @(posedge clk); #1;
    checkOutput({tag, "_finished"}, busy0, 0);
  endtask

  // Expected RAM image derived from the consumed bytes: address a holds bit (a mod 8) of byte a/8.
  task automatic checkImage(input string tag, input int n_bytes, input int n_writes, input bit tight);
    int bad_addr = 0;
    int bad0 = 0;
    int bad1 = 0;
    int bad_gap = 0;
    int b, p;
    checkOutput({tag, "_handshakes"}, hs_data.size(), n_bytes);
    checkOutput({tag, "_writes"}, wr_addr.size(), n_writes);
    for (int a = 0; a < wr_addr.size(); a++) begin
      b = a / 8;
      p = a % 8;
      if (int'(wr_addr[a]) != a) bad_addr++;
      if (b < hs_data.size()) begin
        if (wr_d0[a] !== hs_data[b][p]) bad0++;
        if (wr_d1[a] !== hs_data[b][7-p]) bad1++;
      end else begin
        bad0++;
      end
    end
    checkOutput({tag, "_addr_seq"}, bad_addr, 0);
    checkOutput({tag, "_bits_lsb_first"}, bad0, 0);
    checkOutput({tag, "_bits_msb_first"}, bad1, 0);
    checkOutput({tag, "_lockstep"}, lock_err, 0);
    if (tight) begin
      for (int i = 1; i < hs_cyc.size(); i++)
        if (hs_cyc[i] - hs_cyc[i-1] != 8) bad_gap++;
      checkOutput({tag, "_byte_spacing"}, bad_gap, 0);
      if (wr_cyc.size() > 0) checkOutput({tag, "_span"}, wr_cyc[$] - wr_cyc[0], DEPTH - 1);
    end
  endtask

  task automatic checkDone(input string tag, input int exp_count);
    checkOutput({tag, "_done_count"}, done_cyc.size(), exp_count);
    if (done_cyc.size() > 0 && wr_cyc.size() > 0)
      checkOutput({tag, "_done_lag"}, done_cyc[0] - wr_cyc[$], 1);
    checkOutput({tag, "_done_busy_we"}, done_err, 0);
  endtask

  task automatic checkFirstByte(input string tag, input bit msb_inst);
    logic [7:0] v = '0;
    if (wr_d0.size() >= 9) begin
      for (int i = 0; i < 8; i++) v = {v[6:0], msb_inst ? wr_d1[i] : wr_d0[i]};
      checkOutput({tag, "_addr0to7"}, v, 8'hA5);
      if (!msb_inst) checkOutput({tag, "_addr8"}, wr_d0[8], 1'b1);
    end
  endtask

  initial begin
    rst_n = 1'b0; clear_start = 1'b0; load_start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0;
    resetLogs();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_we", if0.we, 0);
    checkOutput("reset_waddr", if0.waddr, 0);
    checkOutput("reset_wdata", if0.wdata, 0);
    checkOutput("reset_in_ready", if0.in_ready, 0);
    checkOutput("reset_busy", busy0, 0);
    checkOutput("reset_done", done0, 0);
    rst_n = 1'b1;

    // Reset asserted in the middle of a clear.
    @(posedge clk); #1;
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("midclear_we", if0.we, 1);
    resetLogs();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_we", if0.we, 0);
    checkOutput("rst_mid_busy", busy0, 0);
    checkOutput("rst_mid_in_ready", if0.in_ready, 0);
    checkOutput("rst_mid_waddr", if0.waddr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    checkOutput("rst_mid_no_done", done_cyc.size(), 0);
    checkOutput("rst_mid_idle", busy0, 0);

    runClear("clear", 1'b0);

    applyStimulus("load_tight", 0, 1'b0, -1);
    checkImage("load_tight", DEPTH / 8, DEPTH, 1'b1);
    checkDone("load_tight", 1);
    checkFirstByte("load_tight_lsb", 1'b0);

    applyStimulus("load_gap3", 3, 1'b0, -1);
    checkImage("load_gap3", DEPTH / 8, DEPTH, 1'b0);
    checkDone("load_gap3", 1);
    checkFirstByte("load_gap3_msb", 1'b1);

    applyStimulus("load_rand", 0, 1'b1, -1);
    checkImage("load_rand", DEPTH / 8, DEPTH, 1'b0);
    checkDone("load_rand", 1);

    // Abort on byte 3, bit 4: the write at address 28 is the last one.
    applyStimulus("abort", 0, 1'b1, 28);
    checkImage("abort", 4, 29, 1'b0);
    checkDone("abort", 0);
    if (wr_addr.size() > 0) checkOutput("abort_last_addr", wr_addr[$], 28);

    applyStimulus("after_abort", 0, 1'b1, -1);
    checkImage("after_abort", DEPTH / 8, DEPTH, 1'b0);
    checkDone("after_abort", 1);
    if (wr_addr.size() > 0) checkOutput("after_abort_first_addr", wr_addr[0], 0);

    runClear("clear_both", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/voxel_ram_loader.md
Name: voxel_ram_loader

Overview:
Write-side front end for the single-bit voxel occupancy RAM. It accepts a byte stream over a valid/ready handshake, unpacks each byte into 8 consecutive single-bit writes, and drives the RAM write port (we/waddr/wdata). It also provides a zero-fill (clear) mode that writes 0 to every address. Raytracer read logic uses the RAM only while this block is not busy.

Parameters:
ADDR_BITS, 15, voxel RAM address width; DEPTH = 2^ADDR_BITS bits; legal range >= 3.
LSB_FIRST, 1, 1: byte bit 0 goes to the lowest address of its group; 0: bit 7 goes first.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
clear_start  input  1  1-cycle pulse: zero-fill entire RAM
load_start  input  1  1-cycle pulse: load entire RAM from byte stream starting at address 0
abort  input  1  synchronous cancel of any operation in progress
in_valid  input  1  stream byte valid
in_data  input  8  stream byte
in_ready  output  1  block can accept in_data this cycle
we  output  1  RAM write enable
waddr  output  ADDR_BITS  RAM write address
wdata  output  1  RAM write data
busy  output  1  high in any state other than IDLE
done  output  1  1-cycle pulse on normal completion of a clear or load

Behaviour:
- State registers: state (IDLE, CLEAR, LOAD_WAIT, LOAD_SHIFT), addr[ADDR_BITS-1:0], bitcnt[2:0], shreg[7:0], done flop.
- Reset values: state=IDLE, addr=0, bitcnt=0, shreg=0, done=0. Resulting outputs: we=0, waddr=0, wdata=0, in_ready=0, busy=0.
- we, waddr, wdata, in_ready and busy decode from registered state only. No combinational path from any input to any output.
- waddr = addr in all states. wdata = 0 in CLEAR and IDLE.
- IDLE:
  - clear_start -> CLEAR with addr=0.
  - else load_start -> LOAD_WAIT with addr=0.
  - If both are asserted, clear wins.
  - clear_start and load_start are ignored in every state except IDLE.
- CLEAR:
  - we=1, wdata=0 every cycle; addr increments by 1.
  - In the cycle with addr==DEPTH-1: perform the final write, then next state IDLE, done=1 for the following cycle, addr wraps to 0.
  - Total: exactly DEPTH write cycles.
- LOAD_WAIT:
  - in_ready=1, we=0.
  - On in_valid&&in_ready: shreg<=in_data, bitcnt<=0, go to LOAD_SHIFT.
  - in_valid low: stay.
- LOAD_SHIFT:
  - we=1.
  - wdata = shreg[bitcnt] if LSB_FIRST, else shreg[7-bitcnt].
  - addr++, bitcnt++ each cycle.
- Back-to-back overlap in LOAD_SHIFT:
  - in_ready=1 only when bitcnt==7 and addr!=DEPTH-1.
  - If a handshake occurs in that cycle: load the new byte into shreg, bitcnt wraps to 0, stay in LOAD_SHIFT. Sustained throughput is 8 cycles per byte.
  - With bitcnt==7 and no handshake: go to LOAD_WAIT.
- Load completion: with bitcnt==7 and addr==DEPTH-1, write the last bit, go to IDLE, pulse done, addr wraps to 0. Exactly DEPTH/8 bytes are consumed per load.
- abort:
  - Sampled at the clock edge in any non-IDLE state. Next state IDLE, bitcnt=0, addr=0, no done pulse.
  - The write presented in the abort cycle still occurs; we=0 from the next cycle.
  - abort in IDLE has no effect. abort wins over a same-cycle handshake: the byte is consumed but not written.
- done is never asserted together with we on the following cycle; next operation may start the cycle done is high.
- Reset mid-operation: immediate return to reset values. RAM contents are undefined-partial; no done.
- Write ordering: addresses strictly ascending 0..DEPTH-1 with no gaps or repeats on an unaborted run.

Test Plan:
- Reset then idle, ADDR_BITS=6: hold rst_n low mid-CLEAR -> we=0, busy=0, in_ready=0 immediately; no done after release.
- Clear, ADDR_BITS=6: clear_start pulse -> we=1 for exactly 64 consecutive cycles, waddr 0..63, wdata=0. done pulses once, the cycle after the waddr=63 write. busy falls the same cycle.
- Load, LSB_FIRST=1, ADDR_BITS=6: bytes 0xA5,0x01,... with in_valid held high -> writes at addr 0..7 = 1,0,1,0,0,1,0,1 and addr 8 = 1. Bytes accepted every 8 cycles after the first. Exactly 8 handshakes; done after addr 63. in_ready=0 in the final bit-7 cycle.
- Load, LSB_FIRST=0, in_valid gapped 3 cycles between bytes: byte 0xA5 -> addr 0..7 = 1,0,1,0,0,1,0,1. During gaps we=0 and in_ready=1. No lost or duplicated bits.
- Abort at byte 3, bitcnt=4, ADDR_BITS=6: last write at addr 28, then we=0, busy=0, no done. A following load_start restarts at waddr=0.
- Simultaneous clear_start and load_start in IDLE -> CLEAR runs and in_ready stays 0. A load_start pulse during CLEAR is ignored.
